// File: rtl/hazard_control_dmem_pkg.sv
// Shared encodings for the decode-stage control, ALU-control and data-memory slice.
package hazard_control_dmem_pkg;

    typedef enum logic [6:0] {
        OP_R      = 7'b0110011,
        OP_I      = 7'b0010011,
        OP_LOAD   = 7'b0000011,
        OP_STORE  = 7'b0100011,
        OP_BRANCH = 7'b1100011
    } opcode_e;

    typedef enum logic [1:0] {
        ALUOP_MEM    = 2'b00,
        ALUOP_BRANCH = 2'b01,
        ALUOP_FUNCT  = 2'b10
    } aluop_e;

    typedef enum logic [3:0] {
        ALU_AND = 4'b0000,
        ALU_OR  = 4'b0001,
        ALU_ADD = 4'b0010,
        ALU_SUB = 4'b0110
    } aluctr_e;

    localparam logic [2:0] F3_ADD = 3'b000;
    localparam logic [2:0] F3_OR  = 3'b110;
    localparam logic [2:0] F3_AND = 3'b111;

endpackage

// File: rtl/hazard_control_dmem_dmem_array.sv
// 64-bit word data memory; reset loads word i with i, combinational gated read.
module dmem_array
    import hazard_control_dmem_pkg::*;
#(
    parameter int DEPTH = 32,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [AW-1:0] index,
    input  logic [63:0]   write_data,
    input  logic          we,
    input  logic          re,
    output logic [63:0]   read_data
);

    logic [63:0] mem [DEPTH];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[AW'(i)] <= 64'(i);
            end
        end else if (we) begin
            mem[index] <= write_data;
        end
    end

    assign read_data = re ? mem[index] : '0;

endmodule

// File: rtl/hazard_control_dmem.sv
// ID-stage main/ALU control decode, load-use stall detection and MEM-stage data memory.
module hazard_control_dmem
    import hazard_control_dmem_pkg::*;
#(
    parameter int DEPTH = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instruction,
    output logic        idex_branch,
    output logic        idex_memread,
    output logic        idex_memtoreg,
    output logic        idex_memwrite,
    output logic        idex_alusrc,
    output logic        idex_regwrite,
    output logic [1:0]  idex_ALUop,
    output logic [3:0]  idex_ALUctr,
    input  logic [4:0]  idex_rd,
    input  logic [4:0]  ifid_rs1,
    input  logic [4:0]  ifid_rs2,
    output logic        stall,
    input  logic [63:0] address,
    input  logic [63:0] write_data,
    input  logic        exmem_write,
    input  logic        exmem_read,
    output logic [63:0] memwb_readdata
);

    localparam int AW = $clog2(DEPTH);

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       f7b5;
    logic       is_rtype;
    aluop_e     aluop;
    aluctr_e    aluctr;

    assign opcode = instruction[6:0];
    assign funct3 = instruction[14:12];
    assign f7b5   = instruction[30];

    always_comb begin
        idex_branch   = 1'b0;
        idex_memread  = 1'b0;
        idex_memtoreg = 1'b0;
        idex_memwrite = 1'b0;
        idex_alusrc   = 1'b0;
        idex_regwrite = 1'b0;
        is_rtype      = 1'b0;
        aluop         = ALUOP_MEM;
        case (opcode)
            OP_R: begin
                idex_regwrite = 1'b1;
                is_rtype      = 1'b1;
                aluop         = ALUOP_FUNCT;
            end
            OP_I: begin
                idex_alusrc   = 1'b1;
                idex_regwrite = 1'b1;
                aluop         = ALUOP_FUNCT;
            end
            OP_LOAD: begin
                idex_alusrc   = 1'b1;
                idex_memtoreg = 1'b1;
                idex_regwrite = 1'b1;
                idex_memread  = 1'b1;
            end
            OP_STORE: begin
                idex_alusrc   = 1'b1;
                idex_memwrite = 1'b1;
            end
            OP_BRANCH: begin
                idex_branch = 1'b1;
                aluop       = ALUOP_BRANCH;
            end
            default: ;
        endcase
    end

    // f7b5 selects subtract only for register-register ops; immediates carry data there.
    always_comb begin
        aluctr = ALU_ADD;
        case (aluop)
            ALUOP_BRANCH: aluctr = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct3)
                    F3_ADD:  aluctr = (is_rtype && f7b5) ? ALU_SUB : ALU_ADD;
                    F3_AND:  aluctr = ALU_AND;
                    F3_OR:   aluctr = ALU_OR;
                    default: aluctr = ALU_ADD;
                endcase
            end
            default: aluctr = ALU_ADD;
        endcase
    end

    assign idex_ALUop  = aluop;
    assign idex_ALUctr = aluctr;

    assign stall = idex_memread && (idex_rd != 5'd0)
                   && ((idex_rd == ifid_rs1) || (idex_rd == ifid_rs2));

    logic unused_bits;
    assign unused_bits = ^{instruction[31], instruction[29:15], instruction[11:7],
                           address[63:AW+3], address[2:0]};

    dmem_array #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_dmem (
        .clk        (clk),
        .reset      (reset),
        .index      (address[AW+2:3]),
        .write_data (write_data),
        .we         (exmem_write),
        .re         (exmem_read),
        .read_data  (memwb_readdata)
    );

endmodule

// File: tb/tb_hazard_control_dmem.sv
// Self-checking bench: spec-level model compared every cycle plus literal expectations.
module tb_hazard_control_dmem;

    localparam int DEPTH = 32;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] instruction;
    logic        idex_branch, idex_memread, idex_memtoreg, idex_memwrite;
    logic        idex_alusrc, idex_regwrite;
    logic [1:0]  idex_ALUop;
    logic [3:0]  idex_ALUctr;
    logic [4:0]  idex_rd, ifid_rs1, ifid_rs2;
    logic        stall;
    logic [63:0] address, write_data;
    logic        exmem_write, exmem_read;
    logic [63:0] memwb_readdata;

    int errors = 0;
    int checks = 0;
    bit cmp_en = 1'b0;

    logic [63:0] model_mem [DEPTH];

    hazard_control_dmem #(.DEPTH(DEPTH)) dut (
        .clk            (clk),
        .reset          (reset),
        .instruction    (instruction),
        .idex_branch    (idex_branch),
        .idex_memread   (idex_memread),
        .idex_memtoreg  (idex_memtoreg),
        .idex_memwrite  (idex_memwrite),
        .idex_alusrc    (idex_alusrc),
        .idex_regwrite  (idex_regwrite),
        .idex_ALUop     (idex_ALUop),
        .idex_ALUctr    (idex_ALUctr),
        .idex_rd        (idex_rd),
        .ifid_rs1       (ifid_rs1),
        .ifid_rs2       (ifid_rs2),
        .stall          (stall),
        .address        (address),
        .write_data     (write_data),
        .exmem_write    (exmem_write),
        .exmem_read     (exmem_read),
        .memwb_readdata (memwb_readdata)
    );

    always #5 clk = ~clk;

    // Packed as {branch, memread, memtoreg, memwrite, alusrc, regwrite, ALUop[1:0], ALUctr[3:0]}.
    function automatic logic [11:0] exp_decode(input logic [31:0] ins);
        logic [6:0] op;
        logic [2:0] f3;
        bit is_r, is_i, is_ld, is_st, is_br;
        logic [1:0] aop;
        logic [3:0] ctr;
        op = ins[6:0];
        f3 = ins[14:12];
        is_r  = (op == 7'h33);
        is_i  = (op == 7'h13);
        is_ld = (op == 7'h03);
        is_st = (op == 7'h23);
        is_br = (op == 7'h63);
        aop = (is_r || is_i) ? 2'd2 : (is_br ? 2'd1 : 2'd0);
        if (is_br)                         ctr = 4'd6;
        else if (!(is_r || is_i))          ctr = 4'd2;
        else if (f3 == 3'd7)               ctr = 4'd0;
        else if (f3 == 3'd6)               ctr = 4'd1;
        else if (f3 == 3'd0 && is_r && ins[30]) ctr = 4'd6;
        else                               ctr = 4'd2;
        return {is_br, is_ld, is_ld, is_st, (is_i || is_ld || is_st),
                (is_r || is_i || is_ld), aop, ctr};
    endfunction

    function automatic int word_of(input logic [63:0] a);
        return int'((a >> 3) % DEPTH);
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) model_mem[i] = 64'(i);
    endtask

    // Advance one edge, applying the write the model expects, then move off the edge.
    task automatic tick();
        @(posedge clk);
        if (!reset && exmem_write) model_mem[word_of(address)] = write_data;
        #2;
    endtask

    function automatic logic [11:0] dut_decode();
        return {idex_branch, idex_memread, idex_memtoreg, idex_memwrite, idex_alusrc,
                idex_regwrite, idex_ALUop, idex_ALUctr};
    endfunction

    always @(negedge clk) begin
        if (cmp_en) begin
            logic [11:0] ed;
            logic        es;
            ed = exp_decode(instruction);
            es = ed[10] && (idex_rd != 5'd0) && (idex_rd == ifid_rs1 || idex_rd == ifid_rs2);
            check("cmp_decode", 64'(dut_decode()), 64'(ed));
            check("cmp_stall", 64'(stall), 64'(es));
            check("cmp_readdata", memwb_readdata,
                  exmem_read ? model_mem[word_of(address)] : 64'd0);
        end
    end

    logic [31:0] itab [10] = '{32'h002081B3, 32'h402081B3, 32'h00813183, 32'h00313423,
                               32'h00208463, 32'h00000000, 32'h40008093, 32'h0000F093,
                               32'h0020E1B3, 32'h0020C1B3};
    logic [11:0] dtab [10] = '{12'b000001100010, 12'b000001100110, 12'b011011000010,
                               12'b000110000010, 12'b100000010110, 12'b000000000010,
                               12'b000011100010, 12'b000011100000, 12'b000001100001,
                               12'b000001100010};

    initial begin
        reset = 1'b1;
        instruction = '0;
        idex_rd = '0; ifid_rs1 = '0; ifid_rs2 = '0;
        address = '0; write_data = '0;
        exmem_write = 1'b0; exmem_read = 1'b0;
        model_reset();
        #1;
        check("reset_readdata_gated", memwb_readdata, 64'd0);
        check("reset_decode_bubble", 64'(dut_decode()), 64'(12'b000000000010));
        #11;
        reset = 1'b0;
        cmp_en = 1'b1;
        tick();

        // Decode literals
        for (int i = 0; i < 10; i++) begin
            instruction = itab[i];
            #1;
            check($sformatf("decode_%08h", itab[i]), 64'(dut_decode()), 64'(dtab[i]));
            tick();
        end

        // Hazard literals
        instruction = 32'h00813183; idex_rd = 5'd3; ifid_rs1 = 5'd0; ifid_rs2 = 5'd3;
        #1; check("stall_load_rs2", 64'(stall), 64'd1);
        ifid_rs1 = 5'd3; ifid_rs2 = 5'd9;
        #1; check("stall_load_rs1", 64'(stall), 64'd1);
        instruction = 32'h002081B3;
        #1; check("stall_no_memread", 64'(stall), 64'd0);
        instruction = 32'h00813183; idex_rd = 5'd0; ifid_rs1 = 5'd0;
        #1; check("stall_rd_zero", 64'(stall), 64'd0);
        idex_rd = 5'd4; ifid_rs1 = 5'd5; ifid_rs2 = 5'd6;
        #1; check("stall_no_match", 64'(stall), 64'd0);
        tick();

        // Memory after reset
        exmem_read = 1'b1; address = 64'd40;
        #1; check("rd_addr40", memwb_readdata, 64'd5);
        address = 64'(8 * DEPTH + 16);
        #1; check("rd_wrap", memwb_readdata, 64'd2);
        address = 64'd43;
        #1; check("rd_byte_bits_ignored", memwb_readdata, 64'd5);
        exmem_read = 1'b0;
        #1; check("rd_disabled", memwb_readdata, 64'd0);
        tick();

        // Write then read back
        exmem_write = 1'b1; address = 64'd24; write_data = 64'hDEAD;
        tick();
        exmem_write = 1'b0; exmem_read = 1'b1;
        #1; check("wr_readback", memwb_readdata, 64'hDEAD);
        address = 64'd32;
        #1; check("wr_neighbour", memwb_readdata, 64'd4);
        tick();

        // Same-word read and write: old value until the edge
        address = 64'd48; write_data = 64'h1234; exmem_write = 1'b1;
        #1; check("rw_same_old", memwb_readdata, 64'd6);
        tick();
        exmem_write = 1'b0;
        #1; check("rw_same_new", memwb_readdata, 64'h1234);

        // Asynchronous reset pulse between edges
        address = 64'd24;
        reset = 1'b1; model_reset();
        #1; check("async_reset_word3", memwb_readdata, 64'd3);
        reset = 1'b0;
        tick();

        // Write pending on an edge while reset is held is discarded
        reset = 1'b1; exmem_write = 1'b1; address = 64'd56; write_data = 64'hBAD;
        tick();
        reset = 1'b0; exmem_write = 1'b0;
        #1; check("reset_blocks_write", memwb_readdata, 64'd7);
        tick();

        // Mixed traffic checked by the per-cycle compare
        for (int i = 0; i < 24; i++) begin
            instruction = itab[i % 10];
            idex_rd  = 5'($urandom_range(0, 3));
            ifid_rs1 = 5'($urandom_range(0, 3));
            ifid_rs2 = 5'($urandom_range(0, 3));
            address  = 64'(i * 24 + (i % 8)) + (64'(i % 3) << 40);
            write_data = {$urandom, $urandom};
            exmem_write = (i % 3) != 2;
            exmem_read  = (i % 4) != 0;
            tick();
        end
        exmem_write = 1'b0;
        exmem_read = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            address = 64'(i * 8);
            tick();
        end

        cmp_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
